// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - shared constants and state encoding for the load sequencer
// Purpose: counter geometry, direction encoding and the sequencer state enum.
// Optional build macro used by load_seq: LOAD_SEQ_SAT_REJECT_EN.
package load_pkg;

  localparam int CNT_W   = 3;                // shadow count width, matches the counter
  localparam int CNT_MAX = (1 << CNT_W) - 1; // saturation ceiling
  localparam int LEN_W   = 3;                // burst length field width

  localparam logic DIR_LOAD   = 1'b1;
  localparam logic DIR_UNLOAD = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    FIN
  } state_t;

endpackage

// File: rtl/load_shadow_cnt.sv
// rtl/load_shadow_cnt.sv - saturating up/down shadow of the occupancy counter
// Purpose: tracks the external counter value one step per enabled clock.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (count -> 0)
//   en          : step this cycle
//   dir         : DIR_LOAD increments, DIR_UNLOAD decrements
//   count       : current value, saturates at 0 and CNT_MAX
//   full, empty : decoded from the registered count
module load_shadow_cnt
  import load_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  assign full  = (count == CNT_W'(CNT_MAX));
  assign empty = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      if (dir == DIR_LOAD) begin
        if (!full) count <= count + 1'b1;
      end else begin
        if (!empty) count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/load_seq.sv
// rtl/load_seq.sv - burst request to glitch-safe X/P strobe sequencer
// Purpose: accepts (dir, len) bursts over valid/ready and emits len X/P strobes,
// keeping a shadow of the counter value.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   req_valid/req_ready     : request handshake, ready only while idle
//   req_dir, req_len        : burst direction (1 = load) and strobe count
//   done                    : one-cycle pulse when a burst completes
//   err                     : one-cycle pulse on a rejected saturating strobe
//   X, P                    : direction level and enable strobe to the counter
//   count, full, empty      : shadow counter value and its limits
// Build option: LOAD_SEQ_SAT_REJECT_EN suppresses strobes that would saturate
// and pulses err instead; without it err is tied low.
module load_seq
  import load_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_dir,
  input  logic [LEN_W-1:0] req_len,
  output logic             req_ready,
  output logic             done,
  output logic             err,
  output logic             X,
  output logic             P,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  state_t           state;
  state_t           state_nxt;
  logic             dir_q;
  logic [LEN_W-1:0] rem;
  logic             accept;
  logic             dir_eff;
  logic             strobe_ok;

  assign accept  = req_valid && req_ready;
  // On the accept edge the latched direction is not yet valid, so the
  // SETUP-cycle X value comes straight from the request.
  assign dir_eff = accept ? req_dir : dir_q;

`ifdef LOAD_SEQ_SAT_REJECT_EN
  logic sat;
  // count only moves at the end of PULSE, so it is stable when deciding
  // whether the upcoming strobe would push past a limit.
  assign sat       = (dir_q == DIR_LOAD) ? full : empty;
  assign strobe_ok = !sat;
`else
  assign strobe_ok = 1'b1;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (req_len != '0) ? SETUP : FIN;
      SETUP:   state_nxt = PULSE;
      PULSE:   state_nxt = HOLD;
      // rem was already decremented at the end of PULSE
      HOLD:    state_nxt = (rem != '0) ? PULSE : FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are clean Moore
  // levels aligned with the state they describe; X only moves on the
  // IDLE->SETUP and HOLD->FIN edges, where P is low on both sides.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dir_q     <= DIR_UNLOAD;
      rem       <= '0;
      X         <= 1'b0;
      P         <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b1;
`ifdef LOAD_SEQ_SAT_REJECT_EN
      err       <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        dir_q <= req_dir;
        rem   <= req_len;
      end else if (state == PULSE) begin
        rem <= rem - 1'b1;
      end
      X         <= (state_nxt == SETUP || state_nxt == PULSE || state_nxt == HOLD)
                   ? dir_eff : 1'b0;
      P         <= (state_nxt == PULSE) && strobe_ok;
      done      <= (state_nxt == FIN);
      req_ready <= (state_nxt == IDLE);
`ifdef LOAD_SEQ_SAT_REJECT_EN
      err       <= (state_nxt == PULSE) && sat;
`endif
    end
  end

  // P is only ever high during PULSE, so it doubles as the shadow enable and
  // the shadow steps on the same edge as the external counter.
  load_shadow_cnt u_shadow (
    .clk   (clk),
    .reset (reset),
    .en    (P),
    .dir   (dir_q),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_load_seq.sv
// tb/tb_load_seq.sv - self-checking bench for load_seq
module tb_load_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_dir;
  logic [2:0] req_len;
  logic       req_ready;
  logic       done;
  logic       err;
  logic       X;
  logic       P;
  logic [2:0] count;
  logic       full;
  logic       empty;

  int n_cmp = 0;
  int n_bad = 0;
  int m     = 0;   // expected counter value from burst-level arithmetic

`ifdef LOAD_SEQ_SAT_REJECT_EN
  localparam bit REJ = 1'b1;
`else
  localparam bit REJ = 1'b0;
`endif

  logic [2:0] ref_cnt; // independent counter driven only by X/P/clk

  load_seq dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_dir   (req_dir),
    .req_len   (req_len),
    .req_ready (req_ready),
    .done      (done),
    .err       (err),
    .X         (X),
    .P         (P),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) ref_cnt <= 3'd0;
    else if (P) ref_cnt <= X ? ((ref_cnt == 3'd7) ? 3'd7 : ref_cnt + 3'd1)
                             : ((ref_cnt == 3'd0) ? 3'd0 : ref_cnt - 3'd1);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " count"}, 8'(count), 8'd0);
    chk({tag, " empty"}, 8'(empty), 8'd1);
    chk({tag, " full"},  8'(full),  8'd0);
    chk({tag, " ready"}, 8'(req_ready), 8'd1);
    chk({tag, " X"},     8'(X), 8'd0);
    chk({tag, " P"},     8'(P), 8'd0);
    chk({tag, " done"},  8'(done), 8'd0);
    chk({tag, " err"},   8'(err), 8'd0);
  endtask

  // Called at a negedge with the DUT idle. Returns at the negedge of the
  // cycle where req_ready is high again. With hold set, req_valid stays high
  // throughout and dir/len are scrambled while ready is low.
  task automatic burst(input bit d, input int n, input bit hold);
    int  done_k;
    int  last;
    bit  sat;
    bit  exp_p;
    bit  exp_e;
    bit  exp_x;
    bit  strobe;
    req_valid = 1'b1;
    req_dir   = d;
    req_len   = 3'(n);
    chk("ready before accept", 8'(req_ready), 8'd1);
    @(posedge clk);
    done_k = (n == 0) ? 1 : 2 * n + 2;
    last   = done_k + 1;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      else if (k < last) begin
        req_dir = 1'($urandom);
        req_len = 3'($urandom);
      end
      strobe = (n > 0) && (k % 2 == 0) && (k <= 2 * n);
      sat    = d ? (m == 7) : (m == 0);
      exp_p  = strobe && !(REJ && sat);
      exp_e  = strobe && REJ && sat;
      exp_x  = (n > 0) && (k <= 2 * n + 1) && d;
      chk($sformatf("P k=%0d", k),     8'(P), 8'(exp_p));
      chk($sformatf("X k=%0d", k),     8'(X), 8'(exp_x));
      chk($sformatf("err k=%0d", k),   8'(err), 8'(exp_e));
      chk($sformatf("done k=%0d", k),  8'(done), 8'(k == done_k));
      chk($sformatf("ready k=%0d", k), 8'(req_ready), 8'(k == last));
      chk($sformatf("count k=%0d", k), 8'(count), 8'(m));
      chk($sformatf("full k=%0d", k),  8'(full), 8'(m == 7));
      chk($sformatf("empty k=%0d", k), 8'(empty), 8'(m == 0));
      chk($sformatf("refcnt k=%0d", k), 8'(count), 8'(ref_cnt));
      if (exp_p) m = d ? ((m < 7) ? m + 1 : 7) : ((m > 0) ? m - 1 : 0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_dir   = 1'b0;
    req_len   = 3'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("reset");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle P", 8'(P), 8'd0);
      chk("idle ready", 8'(req_ready), 8'd1);
    end

    burst(1'b1, 3, 1'b0);          // load 3
    burst(1'b1, 7, 1'b0);          // run into saturation
    burst(1'b1, 2, 1'b0);          // fully saturating burst
    burst(1'b0, 5, 1'b0);          // down to 2
    burst(1'b0, 4, 1'b0);          // unload past empty
    burst(1'b1, 0, 1'b0);          // zero length
    burst(1'b1, 2, 1'b1);          // valid held through the burst
    burst(1'b0, 1, 1'b0);          // accepted back-to-back at ready

    for (int i = 0; i < 14; i++)
      burst(1'($urandom), int'($urandom_range(0, 7)), 1'($urandom));

    // Reset during the second PULSE of a length-5 load.
    req_valid = 1'b1;
    req_dir   = 1'b1;
    req_len   = 3'd5;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    chk("midburst P before reset", 8'(P), 8'd1);
    reset = 1'b1;
    #1;
    chk_reset_vals("midburst");
    m = 0;
    @(negedge clk);
    reset = 1'b0;
    burst(1'b1, 2, 1'b0);
    chk("after midburst count", 8'(count), 8'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
